// File: rtl/sine_rom_pkg.sv
// Shared types and defaults for the sine ROM arbiter slice.
// Holds address/data defaults, index width helper and in-flight tag.
package sine_rom_pkg;

   localparam int SR_ADDR_W = 8;
   localparam int SR_DATA_W = 16;
   localparam int STATS_W   = 16;
   localparam int TAG_IDX_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin grant with registered priority pointer.
// Grant is combinational and forced low while rst_n is asserted.
module rr_arbiter
   import sine_rom_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IW   = idx_w(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [IW-1:0]   r_ptr;
   logic [NREQ-1:0] w_rot;
   logic            w_hit;
   int              w_k;

   always_comb begin
      w_rot = NREQ'({req, req} >> r_ptr);
      w_hit = 1'b0;
      w_k   = 0;
      for (int o = 0; o < NREQ; o++) begin
         if (!w_hit && w_rot[o]) begin
            w_hit = 1'b1;
            w_k   = int'(r_ptr) + o;
            if (w_k >= NREQ) w_k = w_k - NREQ;
         end
      end
      if (!rst_n) w_hit = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         gnt[j] = w_hit && (w_k == j);
      end
      gnt_idx = w_hit ? IW'(w_k) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_hit) begin
         r_ptr <= (w_k + 1 >= NREQ) ? '0 : IW'(w_k + 1);
      end
   end

endmodule

// File: rtl/sine_rom_arb.sv
// Shares one synchronous sine ROM read port between NREQ requesters.
// Define SINE_ROM_ARB_STATS_EN for per-requester grant counters.
module sine_rom_arb
   import sine_rom_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int ADDR_WIDTH = SR_ADDR_W,
   parameter int DATA_WIDTH = SR_DATA_W,
   parameter int ROM_LAT    = 1
) (
   input  logic                       clk0,
   input  logic                       rst0_n,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NREQ-1:0]            gnt,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic                       rom_cs0,
   output logic [ADDR_WIDTH-1:0]      rom_addr0,
   input  logic [DATA_WIDTH-1:0]      rom_dout0
`ifdef SINE_ROM_ARB_STATS_EN
   ,
   input  logic                       stats_clr,
   output logic [NREQ*STATS_W-1:0]    grant_cnt
`endif
);

   localparam int IW = idx_w(NREQ);

   logic [NREQ-1:0]       w_gnt;
   logic [IW-1:0]         w_gidx;
   logic [ADDR_WIDTH-1:0] w_addr;
   tag_t                  w_tag_in;
   tag_t                  w_tag_out;
   tag_t                  r_tag [ROM_LAT];
   logic [NREQ-1:0]       r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_arb (
      .clk     (clk0),
      .rst_n   (rst0_n),
      .req     (req),
      .gnt     (w_gnt),
      .gnt_idx (w_gidx)
   );

   always_comb begin
      w_addr = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (w_gnt[j]) w_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   assign gnt       = w_gnt;
   assign rom_cs0   = |w_gnt;
   assign rom_addr0 = w_addr;

   assign w_tag_in.valid = |w_gnt;
   assign w_tag_in.idx   = TAG_IDX_W'(w_gidx);
   assign w_tag_out      = r_tag[ROM_LAT-1];

   // Tag slot ROM_LAT-1 lines up with the edge where dout0 is valid
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_tag_in;
         for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         for (int j = 0; j < NREQ; j++) begin
            r_rsp_valid[j] <= w_tag_out.valid &&
                              (int'(w_tag_out.idx) == j);
         end
         if (w_tag_out.valid) r_rsp_data <= rom_dout0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

`ifdef SINE_ROM_ARB_STATS_EN
   logic [STATS_W-1:0] r_cnt [NREQ];

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (stats_clr) begin
               r_cnt[i] <= '0;
            end else if (w_gnt[i] && (r_cnt[i] != '1)) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_cnt[i*STATS_W +: STATS_W] = r_cnt[i];
      end
   end
`endif

endmodule
